// File: rtl/top_level_cpu.sv
// Hardwired signed 16x16 multiply engine: reads 16 big-endian operand pairs from
// bytes 0-63 of its private data memory and writes the 32-bit products to OUT_BASE.

module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    // Plain always so the bench can preload the array hierarchically; contents survive reset.
    always @(posedge clk) begin
        if (we)
            core[addr] <= wdata;
    end

    assign rdata = core[addr];

endmodule

module top_level_cpu #(
    parameter int NUM_PAIRS = 16,
    parameter int OUT_BASE  = 64
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_MUL,
        ST_STORE,
        ST_DONE
    } state_t;

    localparam logic [7:0] OUT_BASE_B = 8'(OUT_BASE);
    localparam logic [3:0] LAST_PAIR  = 4'(NUM_PAIRS - 1);

    state_t      state, state_n;
    logic [3:0]  k, k_n;
    logic [1:0]  b, b_n;
    logic [31:0] opnd;
    logic [31:0] prod;
    logic        done_n;

    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        store_we;
    logic        mem_we;

    // A reset edge must never land a product byte, whatever state the engine is in.
    assign mem_we = store_we & reset;

    data_mem dm1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_n   = state;
        k_n       = k;
        b_n       = b;
        done_n    = 1'b0;
        store_we  = 1'b0;
        mem_addr  = {2'b00, k, b};
        mem_wdata = 8'h00;

        case (state)
            ST_LOAD: begin
                if (b == 2'd3)
                    state_n = ST_MUL;
                else
                    b_n = b + 2'd1;
            end

            ST_MUL: begin
                b_n     = 2'd0;
                state_n = ST_STORE;
            end

            ST_STORE: begin
                store_we = 1'b1;
                mem_addr = OUT_BASE_B + {2'b00, k, b};
                case (b)
                    2'd0:    mem_wdata = prod[31:24];
                    2'd1:    mem_wdata = prod[23:16];
                    2'd2:    mem_wdata = prod[15:8];
                    default: mem_wdata = prod[7:0];
                endcase
                if (b == 2'd3) begin
                    if (k == LAST_PAIR) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        k_n     = k + 4'd1;
                        b_n     = 2'd0;
                        state_n = ST_LOAD;
                    end
                end else begin
                    b_n = b + 2'd1;
                end
            end

            ST_DONE: begin
                done_n = 1'b1;
            end

            default: begin
                state_n = ST_LOAD;
            end
        endcase
    end

    // Operand bytes shift in MSB first, leaving A in [31:16] and B in [15:0].
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_LOAD;
            k     <= 4'd0;
            b     <= 2'd0;
            opnd  <= 32'd0;
            prod  <= 32'd0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            b     <= b_n;
            done  <= done_n;
            if (state == ST_LOAD)
                opnd <= {opnd[23:0], mem_rdata};
            if (state == ST_MUL)
                prod <= $signed(opnd[15:0]) * $signed(opnd[31:16]);
        end
    end

endmodule

// File: tb/tb_top_level_cpu.sv
// Directed and randomized checks of the multiply engine: latency of done,
// product bytes against hand values and a B*A model, mid-run reset, idle after done.

module tb_top_level_cpu;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] opa [16];
    logic [15:0] opb [16];
    logic [7:0]  snap [256];
    int          edges;

    top_level_cpu #(.NUM_PAIRS(16), .OUT_BASE(64)) dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] prodAt(input int k);
        return {dut.dm1.core[64 + 4*k], dut.dm1.core[65 + 4*k],
                dut.dm1.core[66 + 4*k], dut.dm1.core[67 + 4*k]};
    endfunction

    function automatic logic [31:0] modelProd(input int k);
        logic signed [31:0] p;
        p = $signed(opb[k]) * $signed(opa[k]);
        return p;
    endfunction

    task automatic holdReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Preload happens between edges while reset is low.
    task automatic preload(input logic [7:0] outFill, input bit randomRest);
        for (int k = 0; k < 16; k++) begin
            dut.dm1.core[4*k]     = opa[k][15:8];
            dut.dm1.core[4*k + 1] = opa[k][7:0];
            dut.dm1.core[4*k + 2] = opb[k][15:8];
            dut.dm1.core[4*k + 3] = opb[k][7:0];
        end
        for (int i = 64; i < 128; i++)
            dut.dm1.core[i] = outFill;
        for (int i = 128; i < 256; i++)
            dut.dm1.core[i] = randomRest ? 8'($urandom_range(0, 255)) : 8'h00;
    endtask

    task automatic applyStimulus();
        reset = 1'b1;
    endtask

    task automatic waitDone(output int count);
        count = 0;
        do begin
            @(posedge clk);
            count++;
            @(negedge clk);
        end while (!done && count < 400);
    endtask

    task automatic takeSnap();
        for (int i = 0; i < 256; i++)
            snap[i] = dut.dm1.core[i];
    endtask

    function automatic int diffCount(input bit skipOut);
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (!(skipOut && i >= 64 && i < 128) && dut.dm1.core[i] !== snap[i])
                n++;
        return n;
    endfunction

    task automatic checkAllProducts(input string tag);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("%s pair%0d", tag, k), prodAt(k), modelProd(k));
    endtask

    initial begin
        int lowCnt;

        // All-zero operands, outputs pre-filled with a pattern that must be overwritten.
        holdReset();
        for (int k = 0; k < 16; k++) begin
            opa[k] = 16'h0000;
            opb[k] = 16'h0000;
        end
        preload(8'hAA, 1'b0);
        checkOutput("done in reset", {31'd0, done}, 32'd0);
        applyStimulus();
        waitDone(edges);
        checkOutput("zero latency", edges, 32'd144);
        checkAllProducts("zero");

        // Directed corner products with hand-computed results.
        holdReset();
        for (int k = 0; k < 16; k++) begin
            opa[k] = 16'(k * 16'h0111);
            opb[k] = 16'(16'hFFF0 + k);
        end
        opa[0]  = 16'h0003; opb[0]  = 16'hFFFE;
        opa[1]  = 16'hFFFF; opb[1]  = 16'hFFFF;
        opa[5]  = 16'h8000; opb[5]  = 16'h8000;
        opa[6]  = 16'h8000; opb[6]  = 16'h7FFF;
        opa[15] = 16'h7FFF; opb[15] = 16'h7FFF;
        preload(8'h00, 1'b0);
        applyStimulus();
        waitDone(edges);
        checkOutput("directed latency", edges, 32'd144);
        checkOutput("pair0 3*-2", prodAt(0), 32'hFFFFFFFA);
        checkOutput("pair1 -1*-1", prodAt(1), 32'h00000001);
        checkOutput("pair5 min*min", prodAt(5), 32'h40000000);
        checkOutput("pair6 min*max", prodAt(6), 32'hC0008000);
        checkOutput("pair15 max*max", prodAt(15), 32'h3FFF0001);
        checkOutput("pair2 0x222*-14", prodAt(2), 32'hFFFFE224);
        checkAllProducts("directed");

        // Random operands, fresh preload under reset each iteration.
        for (int it = 0; it < 10; it++) begin
            holdReset();
            for (int k = 0; k < 16; k++) begin
                opa[k] = 16'($urandom_range(0, 65535));
                opb[k] = 16'($urandom_range(0, 65535));
            end
            preload(8'($urandom_range(0, 255)), 1'b1);
            takeSnap();
            applyStimulus();
            waitDone(edges);
            checkOutput($sformatf("rand%0d latency", it), edges, 32'd144);
            checkAllProducts($sformatf("rand%0d", it));
            checkOutput($sformatf("rand%0d untouched", it), diffCount(1'b1), 32'd0);
        end

        // Reset pulse for two cycles partway through a run.
        holdReset();
        for (int k = 0; k < 16; k++) begin
            opa[k] = 16'($urandom_range(0, 65535));
            opb[k] = 16'($urandom_range(0, 65535));
        end
        preload(8'h55, 1'b1);
        applyStimulus();
        repeat (50) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("done reset cyc1", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("done reset cyc2", {31'd0, done}, 32'd0);
        applyStimulus();
        waitDone(edges);
        checkOutput("restart latency", edges, 32'd144);
        checkAllProducts("restart");

        // Idle after done: flag holds and memory is frozen.
        takeSnap();
        lowCnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (done !== 1'b1)
                lowCnt++;
        end
        checkOutput("done held", lowCnt, 32'd0);
        checkOutput("mem frozen", diffCount(1'b0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
